// File: rtl/unsigned_seq_divider_if.sv
// ----------------------------------------------------------------------------
// unsigned_seq_divider_if
//   Groups the operand and result handshakes of the sequential divider.
//   The master modport is the side that supplies operands and takes results.
//   The slave modport is the divider itself.
//
//   in_valid / in_ready             operand handshake
//   in_dividend / in_divisor        unsigned operands
//   out_valid / out_ready           result handshake
//   out_quotient / out_remainder    result (quotient rounded when ROUND=1)
//   out_div_by_zero                 result came from a zero divisor
//   busy                            divider is iterating
// ----------------------------------------------------------------------------
interface unsigned_seq_divider_if #(
   parameter int DIVIDEND_WIDTH = 14,
   parameter int DIVISOR_WIDTH  = 8
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DIVIDEND_WIDTH-1:0] in_dividend;
   logic [DIVISOR_WIDTH-1:0]  in_divisor;
   logic                      out_valid;
   logic                      out_ready;
   logic [DIVIDEND_WIDTH-1:0] out_quotient;
   logic [DIVISOR_WIDTH-1:0]  out_remainder;
   logic                      out_div_by_zero;
   logic                      busy;

   modport master (
      output in_valid, in_dividend, in_divisor, out_ready,
      input  in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero, busy
   );

   modport slave (
      input  in_valid, in_dividend, in_divisor, out_ready,
      output in_ready, out_valid, out_quotient, out_remainder, out_div_by_zero, busy
   );
endinterface

// File: rtl/unsigned_seq_divider.sv
// ----------------------------------------------------------------------------
// unsigned_seq_divider
//   Multi-cycle unsigned restoring divider producing one quotient bit per
//   clock. Normalises adder-tree sums (dividend = weighted pixel sum,
//   divisor = weight total) and can stall the pixel pipeline through its
//   valid/ready handshakes.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any division in flight
//   bus    unsigned_seq_divider_if.slave: operand and result handshakes,
//          quotient, remainder, div-by-zero flag and busy indication
//
//   A zero divisor finishes on the accept edge with an all-ones quotient and
//   the low dividend bits as remainder. With ROUND=1 the quotient is rounded
//   to nearest (ties up) on entry to DONE; the remainder stays truncating.
// ----------------------------------------------------------------------------
module unsigned_seq_divider #(
   parameter int DIVIDEND_WIDTH = 14,
   parameter int DIVISOR_WIDTH  = 8,
   parameter int ROUND          = 0
) (
   input logic                  clk,
   input logic                  rst_n,
   unsigned_seq_divider_if.slave bus
);
   localparam int DW    = DIVIDEND_WIDTH;
   localparam int VW    = DIVISOR_WIDTH;
   localparam int CNT_W = $clog2(DW + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_next;
   logic [DW-1:0]    quo;       // dividend shifts out of the top, quotient in at the bottom
   logic [VW-1:0]    rem;       // partial remainder, always < divisor between iterations
   logic [VW-1:0]    dvs;
   logic [CNT_W-1:0] cnt;
   logic             dbz;

   logic             accept;
   logic             zero_div;
   logic             last_iter;
   logic [VW:0]      rem_shift;
   logic [VW:0]      rem_diff;
   logic             sub_ok;
   logic [VW-1:0]    rem_next;
   logic [DW-1:0]    quo_next;
   logic             round_up;
   logic [DW-1:0]    quo_final;

   assign bus.in_ready        = (state == IDLE) || ((state == DONE) && bus.out_ready);
   assign bus.out_valid       = (state == DONE);
   assign bus.busy            = (state == BUSY);
   assign bus.out_quotient    = quo;
   assign bus.out_remainder   = rem;
   assign bus.out_div_by_zero = dbz;

   assign accept    = bus.in_valid && bus.in_ready;
   assign zero_div  = (bus.in_divisor == '0);
   assign last_iter = (cnt == CNT_W'(1));

   // One restoring step. The shifted remainder needs VW+1 bits, but after a
   // conditional subtract it is again below the divisor and fits in VW bits.
   always_comb begin
      rem_shift = {rem, quo[DW-1]};
      rem_diff  = rem_shift - {1'b0, dvs};
      sub_ok    = (rem_shift >= {1'b0, dvs});
      rem_next  = sub_ok ? rem_diff[VW-1:0] : rem_shift[VW-1:0];
      quo_next  = {quo[DW-2:0], sub_ok};
      // 2*rem >= divisor means the fractional part is at least one half.
      round_up  = (ROUND != 0) && ({rem_next, 1'b0} >= {1'b0, dvs});
      quo_final = quo_next + {{(DW-1){1'b0}}, round_up};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every combinational output gets a default first so no path through
   // the case statement leaves it unassigned and infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = zero_div ? DONE : BUSY;
         BUSY: if (last_iter) state_next = DONE;
         DONE: begin
            if (accept)             state_next = zero_div ? DONE : BUSY;
            else if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo <= '0;
         rem <= '0;
         dvs <= '0;
         cnt <= '0;
         dbz <= 1'b0;
      end else if (accept) begin
         if (zero_div) begin
            quo <= '1;
            rem <= bus.in_dividend[VW-1:0];
            dvs <= '0;
            cnt <= '0;
            dbz <= 1'b1;
         end else begin
            quo <= bus.in_dividend;
            rem <= '0;
            dvs <= bus.in_divisor;
            cnt <= CNT_W'(DW);
            dbz <= 1'b0;
         end
      end else if (state == BUSY) begin
         rem <= rem_next;
         cnt <= cnt - CNT_W'(1);
         quo <= last_iter ? quo_final : quo_next;
      end
   end
endmodule

// File: tb/tb_unsigned_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_unsigned_seq_divider
//   Drives a truncating (ROUND=0) and a rounding (ROUND=1) divider with the
//   same operand stream and out_ready. Expected results are pushed to a queue
//   on every accepted pair and popped when a result is taken downstream.
// ----------------------------------------------------------------------------
module tb_unsigned_seq_divider;
   localparam int DW = 14;
   localparam int VW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_dividend = '0;
   logic [VW-1:0] in_divisor = '0;
   logic          out_ready = 1'b1;
   logic          stim_done = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   unsigned_seq_divider_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) bus_t ();
   unsigned_seq_divider_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) bus_r ();

   assign bus_t.in_valid    = in_valid;
   assign bus_t.in_dividend = in_dividend;
   assign bus_t.in_divisor  = in_divisor;
   assign bus_t.out_ready   = out_ready;
   assign bus_r.in_valid    = in_valid;
   assign bus_r.in_dividend = in_dividend;
   assign bus_r.in_divisor  = in_divisor;
   assign bus_r.out_ready   = out_ready;

   unsigned_seq_divider #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .ROUND(0)) dut_t (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_t)
   );

   unsigned_seq_divider #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .ROUND(1)) dut_r (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_r)
   );

   typedef struct {
      logic [DW-1:0] q_t;
      logic [DW-1:0] q_r;
      logic [VW-1:0] r;
      logic          dbz;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int a, input int b);
      exp_t e;
      int   q;
      int   r;
      if (b == 0) begin
         e.q_t = '1;
         e.q_r = '1;
         e.r   = VW'(a % 256);
         e.dbz = 1'b1;
      end else begin
         q     = a / b;
         r     = a % b;
         e.q_t = DW'(q);
         e.q_r = DW'(q + ((2 * r >= b) ? 1 : 0));
         e.r   = VW'(r);
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Scoreboard: sampled on the falling edge, so the handshakes seen here are
   // exactly the ones that complete on the following rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_t.out_valid && out_ready) begin
            check("round_dut_out_valid", bus_r.out_valid, 1);
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_quotient_trunc", bus_t.out_quotient, mon_e.q_t);
               check("sb_quotient_round", bus_r.out_quotient, mon_e.q_r);
               check("sb_remainder_trunc", bus_t.out_remainder, mon_e.r);
               check("sb_remainder_round", bus_r.out_remainder, mon_e.r);
               check("sb_dbz_trunc", bus_t.out_div_by_zero, mon_e.dbz);
               check("sb_dbz_round", bus_r.out_div_by_zero, mon_e.dbz);
            end
         end
         if (in_valid && bus_t.in_ready)
            exp_q.push_back(model(int'(in_dividend), int'(in_divisor)));
      end
   end

   // Presents a pair and holds it until accepted; returns just after the accept edge.
   task automatic send(input int a, input int b);
      int n;
      n           = 0;
      in_valid    = 1'b1;
      in_dividend = DW'(a);
      in_divisor  = VW'(b);
      @(negedge clk);
      while (!bus_t.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts edges after the accept edge until out_valid is visible.
   task automatic wait_result(output int lat);
      lat = 0;
      while (!bus_t.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (lat >= 100) check("result_timeout", 0, 1);
   endtask

   task automatic directed(input string tag, input int a, input int b, input int exp_lat,
                           input int exp_qt, input int exp_qr, input int exp_r, input int exp_dbz);
      int lat;
      send(a, b);
      wait_result(lat);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_q_trunc"}, bus_t.out_quotient, exp_qt);
      check({tag, "_q_round"}, bus_r.out_quotient, exp_qr);
      check({tag, "_rem"}, bus_t.out_remainder, exp_r);
      check({tag, "_dbz"}, bus_t.out_div_by_zero, exp_dbz);
   endtask

   initial begin
      int lat;
      int n;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", bus_t.in_ready, 1);
      check("rst_out_valid", bus_t.out_valid, 0);
      check("rst_busy", bus_t.busy, 0);
      check("rst_quotient", bus_t.out_quotient, 0);
      check("rst_remainder", bus_t.out_remainder, 0);
      check("rst_dbz", bus_t.out_div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed values; consecutive calls also run back-to-back through DONE.
      directed("d12345_42", 12345, 42, 14, 293, 294, 39, 0);
      directed("d16383_1", 16383, 1, 14, 16383, 16383, 0, 0);
      directed("d16383_255", 16383, 255, 14, 64, 64, 63, 0);
      // Zero divisor enters DONE on the accept edge itself.
      directed("d1000_0", 1000, 0, 0, 16383, 16383, 232, 1);

      // Backpressure: hold a result in DONE while a new pair waits.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(500, 3);
      wait_result(lat);
      check("bp_latency", lat, 14);
      in_valid    = 1'b1;
      in_dividend = DW'(77);
      in_divisor  = VW'(5);
      repeat (5) begin
         @(posedge clk);
         #1;
         check("bp_out_valid", bus_t.out_valid, 1);
         check("bp_in_ready", bus_t.in_ready, 0);
         check("bp_busy", bus_t.busy, 0);
         check("bp_quotient_hold", bus_t.out_quotient, 166);
         check("bp_remainder_hold", bus_t.out_remainder, 2);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_accept_busy", bus_t.busy, 1);
      check("bp_accept_out_valid", bus_t.out_valid, 0);
      wait_result(lat);
      check("bp_next_latency", lat, 14);
      check("bp_next_quotient", bus_t.out_quotient, 15);
      check("bp_next_remainder", bus_t.out_remainder, 2);

      // Reset in the middle of an iteration discards the result.
      send(12345, 42);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", bus_t.out_valid, 0);
      check("abort_busy", bus_t.busy, 0);
      check("abort_in_ready", bus_t.in_ready, 1);
      check("abort_quotient", bus_t.out_quotient, 0);
      check("abort_remainder", bus_t.out_remainder, 0);
      check("abort_dbz", bus_t.out_div_by_zero, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", bus_t.in_ready, 1);
      check("post_rst_out_valid", bus_t.out_valid, 0);
      directed("d100_7", 100, 7, 14, 14, 14, 2, 0);

      // Random stream with random downstream backpressure.
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               send(int'($urandom_range(0, 16383)),
                    ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255)));
            end
            stim_done = 1'b1;
         end
         begin
            while (!stim_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
      check("final_out_valid", bus_t.out_valid, 0);
      check("final_in_ready", bus_t.in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
